// File: rtl/adc_fifo_pkg.sv
// Shared constants, register map and bus FSM type for adc_sample_fifo.
package adc_fifo_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned TS_W     = 19;

  // Byte offsets of the registers inside the 16-byte window
  localparam logic [3:0] ADC_FIFO_DATA    = 4'h0;
  localparam logic [3:0] ADC_FIFO_STATUS  = 4'h4;
  localparam logic [3:0] ADC_FIFO_CTRL    = 4'h8;
  localparam logic [3:0] ADC_FIFO_DROPPED = 4'hC;

  // STATUS bit positions
  localparam int unsigned STATUS_COUNT_W   = 9;
  localparam int unsigned STATUS_EMPTY_BIT = 9;
  localparam int unsigned STATUS_FULL_BIT  = 10;
  localparam int unsigned STATUS_OVF_BIT   = 11;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;
  localparam int unsigned CTRL_THR_LSB = 8;
  localparam int unsigned CTRL_THR_W   = 8;

  localparam logic [31:0] EMPTY_READ = 32'h8000_0000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } bus_state_t;

  // Assemble the STATUS register word
  function automatic logic [31:0] status_word(input logic [STATUS_COUNT_W-1:0] count,
                                              input logic empty, input logic full,
                                              input logic ovf);
    logic [31:0] w;
    w = '0;
    w[STATUS_COUNT_W-1:0] = count;
    w[STATUS_EMPTY_BIT]   = empty;
    w[STATUS_FULL_BIT]    = full;
    w[STATUS_OVF_BIT]     = ovf;
    return w;
  endfunction

endpackage

// File: rtl/adc_fifo_mem.sv
// Storage array with independent write/read pointers; head entry is read combinationally.
module adc_fifo_mem
  import adc_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_head_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;

  // Pointer update; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Entry write; contents need no reset
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head_c = r_mem[r_rd_ptr];

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC sample FIFO with memory-mapped DATA/STATUS/CTRL/DROPPED registers and
// a threshold interrupt. Optional feature macro: ADC_FIFO_TIMESTAMP_EN stores a
// 19-bit accepted-sample index with each entry, returned in DATA[30:12].
module adc_sample_fifo
  import adc_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] sample_data,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef ADC_FIFO_TIMESTAMP_EN
  localparam int unsigned MEM_W = SAMPLE_W + TS_W;
`else
  localparam int unsigned MEM_W = SAMPLE_W;
`endif

  bus_state_t r_state, w_next_state;
  logic       w_accept;

  logic [3:0]  r_off;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic        r_pop_pend;
  logic        r_ready;
  logic [31:0] r_rdata;

  logic        r_enable;
  logic [7:0]  r_thr;
  logic        r_ovf;
  logic [15:0] r_dropped;
  logic [CW-1:0] r_count;
  logic        r_irq;

  logic          w_hit, w_empty, w_full, w_resp;
  logic          w_wr_ctrl, w_wr_drop, w_clear, w_pop, w_push_req, w_push, w_drop;
  logic [3:0]    w_req_off;
  logic [31:0]   w_read_val, w_data_word;
  logic [MEM_W-1:0] w_head, w_mem_wdata;
  logic [CW-1:0] w_count_nxt;
  logic          w_enable_nxt;
  logic [7:0]    w_thr_nxt;
  logic          w_unused;

  assign w_hit     = mem_addr[31:4] == BASE_ADDR[31:4];
  assign w_req_off = {mem_addr[3:2], 2'b00};
  assign w_empty   = r_count == '0;
  assign w_full    = r_count == CW'(DEPTH);
  assign w_resp    = r_state == S_RESP;

  // Register side effects take place on the clock edge that leaves RESP
  assign w_wr_ctrl  = w_resp && r_wr && (r_off == ADC_FIFO_CTRL);
  assign w_wr_drop  = w_resp && r_wr && (r_off == ADC_FIFO_DROPPED);
  assign w_clear    = w_wr_ctrl && r_wdata[CTRL_CLR_BIT];
  assign w_pop      = w_resp && r_pop_pend;
  assign w_push_req = sample_valid && r_enable;
  assign w_push     = w_push_req && (!w_full || w_pop) && !w_clear;
  assign w_drop     = w_push_req && w_full && !w_pop && !w_clear;

  assign w_unused = ^{mem_addr[1:0], r_wdata[31:16], r_wdata[7:2]};

`ifdef ADC_FIFO_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  // Free-running index of accepted samples
  always_ff @(posedge clk) begin
    if (reset)       r_ts <= '0;
    else if (w_push) r_ts <= r_ts + TS_W'(1);
  end

  assign w_mem_wdata = {r_ts, sample_data};
  assign w_data_word = {1'b0, w_head};
`else
  assign w_mem_wdata = sample_data;
  assign w_data_word = {20'h0, w_head};
`endif

  adc_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_clear  (w_clear),
    .i_wdata  (w_mem_wdata),
    .o_head_c (w_head)
  );

  // Bus FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Bus FSM next state: one RESP cycle per accepted window hit
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_valid && w_hit) begin
          w_next_state = S_RESP;
          w_accept     = 1'b1;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Read data for the addressed register, sampled at acceptance
  always_comb begin
    w_read_val = '0;
    case (w_req_off)
      ADC_FIFO_DATA:    w_read_val = w_empty ? EMPTY_READ : w_data_word;
      ADC_FIFO_STATUS:  w_read_val = status_word(STATUS_COUNT_W'(r_count), w_empty, w_full, r_ovf);
      ADC_FIFO_CTRL:    w_read_val = {16'h0, r_thr, 6'h0, 1'b0, r_enable};
      ADC_FIFO_DROPPED: w_read_val = {16'h0, r_dropped};
      default:          w_read_val = '0;
    endcase
  end

  // Request capture and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_off      <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_pop_pend <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= w_accept ? w_read_val : 32'h0;
      if (w_accept) begin
        r_off      <= w_req_off;
        r_wr       <= |mem_wstrb;
        r_wdata    <= mem_wdata;
        r_pop_pend <= !(|mem_wstrb) && (w_req_off == ADC_FIFO_DATA) && !w_empty;
      end else begin
        r_pop_pend <= 1'b0;
      end
    end
  end

  // Next values of count and CTRL fields, shared by registers and irq
  always_comb begin
    w_count_nxt  = r_count;
    w_enable_nxt = r_enable;
    w_thr_nxt    = r_thr;
    if (w_wr_ctrl) begin
      w_enable_nxt = r_wdata[CTRL_EN_BIT];
      w_thr_nxt    = r_wdata[CTRL_THR_LSB +: CTRL_THR_W];
    end
    if (w_clear)              w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // FIFO bookkeeping, CTRL, overflow, dropped counter and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_enable  <= 1'b0;
      r_thr     <= 8'd1;
      r_ovf     <= 1'b0;
      r_dropped <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_enable <= w_enable_nxt;
      r_thr    <= w_thr_nxt;
      if (w_clear)     r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
      if (w_wr_drop)                          r_dropped <= '0;
      else if (w_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
      r_irq <= w_enable_nxt && (w_thr_nxt != 8'd0) &&
               (STATUS_COUNT_W'(w_count_nxt) >= STATUS_COUNT_W'(w_thr_nxt));
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign irq       = r_irq;

endmodule

// File: doc/adc_sample_fifo.md
# adc_sample_fifo

- Memory-mapped sample buffer directly downstream of the SPI SAR ADC controller in `soc_adc`.
- Captures each 12-bit conversion result into a FIFO so firmware can drain samples in bursts instead of polling every conversion; at 8 kHz auto-sampling, no samples are lost between CPU visits.
- Raises a level interrupt at a programmable fill threshold.
- Sits on the CPU native memory bus (valid/ready) beside RAM.

## Interface
Parameters:
- `DEPTH`, 16 — FIFO entries; power of two, 4..256.
- `BASE_ADDR`, 32'h0200_0000 — register window base; 16-byte aligned.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  one-cycle strobe from the ADC controller: conversion complete.
- `sample_data`  in  12  conversion result; valid while `sample_valid`=1.
- `mem_valid`  in  1  CPU bus request.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte enables; 0 = read.
- `mem_ready`  out  1  one-cycle acknowledge for a request inside the window.
- `mem_rdata`  out  32  read data; valid when `mem_ready`=1.
- `irq`  out  1  level: enabled and count >= threshold.

## Operation
- Window hit: `mem_addr[31:4] == BASE_ADDR[31:4]`. Misses are ignored, with no ready.
- Registers at word offsets:
  - 0x0 DATA, RO.
    - Read pops one entry.
    - Bit31 = empty flag; bits[11:0] = sample.
    - Empty read returns 32'h8000_0000 and does not pop.
  - 0x4 STATUS, RO.
    - [8:0] count.
    - [9] empty.
    - [10] full.
    - [11] overflow, sticky.
  - 0x8 CTRL, RW.
    - [0] enable, reset 0.
    - [1] clear, self-clearing: flushes the FIFO and clears overflow; reads as 0.
    - [15:8] threshold, reset 8'd1.
  - 0xC DROPPED, RW.
    - 16-bit count of samples lost to full, saturating at 16'hFFFF.
    - Any write clears it.
- Writes to DATA and STATUS are acknowledged and have no effect. Byte strobes are ignored; any nonzero `mem_wstrb` is a full-word write.
- Push: `sample_valid` && enable && !full stores `sample_data`.
  - Push while full: sample dropped, overflow set, DROPPED incremented.
  - Push while disabled: ignored, not counted.
- Simultaneous push and pop: both happen and count is unchanged. When full, the pop frees a slot, so the push succeeds with no overflow.
- Clear coincident with a push: clear wins and the sample is discarded.
- `irq` = enable && (count >= threshold) && threshold != 0. It is registered.

## Timing
- Bus FSM states: IDLE, RESP.
  - IDLE → RESP on a window hit: register address and write data are captured, and the read is computed.
  - RESP drives `mem_ready`=1 and `mem_rdata` for exactly one cycle, then returns to IDLE.
  - A new request is accepted in the cycle after RESP. The CPU drops `mem_valid` in that cycle.
- Latency: `mem_ready` is asserted 1 cycle after `mem_valid` rises; each access is 2 cycles.
- The DATA pop and pointer update happen on the RESP clock edge. A sample pushed in the IDLE→RESP edge is visible in the STATUS count of the next access.
- Sample-to-readable latency is 1 cycle: a `sample_valid` edge is followed by count+1 on the next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is kept separately, log2(DEPTH)+1 bits.
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0, `irq`=0.
  - FIFO empty, overflow=0, DROPPED=0.
  - CTRL = 32'h0000_0100.
  - FSM in IDLE.
- Reset mid-access aborts the access without asserting ready; FIFO contents are lost.

## Configuration
- `ADC_FIFO_TIMESTAMP_EN` defined:
  - A 19-bit free-running accepted-sample index (reset 0, wraps) is stored with each entry.
  - DATA bits[30:12] return that index, so firmware can detect gaps.
- Undefined: DATA bits[30:12] read as 0 and no index storage is synthesized.

## Structure
- Package `adc_fifo_pkg`:
  - register offset constants (`ADC_FIFO_DATA`, `_STATUS`, `_CTRL`, `_DROPPED`);
  - STATUS/CTRL bit-position constants;
  - the FSM state enum;
  - the empty-read value 32'h8000_0000.
- One sub-module: `adc_fifo_mem`, a synchronous dual-pointer storage array with write and read ports. Width is 12 bits, or 31 bits with timestamps. The top level holds the bus FSM, registers, and count.

## Test plan
- Enable, push 2500, read DATA → 32'h0000_09C4. Next DATA read → 32'h8000_0000; STATUS empty=1.
- Push 1000, 2000, 3000, then read DATA three times → returns 1000, 2000, 3000 in order. The count goes 3→0 with correct wrap after DEPTH+3 cumulative pushes.
- Fill 16 entries, push 4 more → STATUS full=1, overflow=1, DROPPED=4. Write CTRL clear → count=0 and overflow=0; DROPPED remains 4 until written.
- Threshold=4: push 3 → irq=0; 4th push → irq=1 on the next cycle; one DATA read → irq=0.
- With the FIFO full, a push in the same cycle as a DATA pop → no overflow and the count stays 16.
- Assert reset during RESP → no `mem_ready` pulse; all outputs at reset values next cycle. With `ADC_FIFO_TIMESTAMP_EN`, indices restart at 0.
